// File: rtl/switch_cfg_pkg.sv
// switch_cfg_pkg: shared types and constants for the switch configuration
// bus slave (switch_cfg_regs) and its register file.
// The error counter is enabled by the SWITCH_CFG_ERR_CNT_EN macro; its
// address offset lives here so both builds see the same constant.
package switch_cfg_pkg;

    // Bus-slave FSM states. The encoding is fixed so legacy code that
    // compares against raw 2-bit values keeps working.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACCESS   = 2'd1,
        ACK      = 2'd2,
        WAIT_REL = 2'd3
    } cfg_state_e;

    // Default location and content of the read-only ID register.
    localparam logic [7:0] DEF_ID_ADDR    = 8'h10;
    localparam logic [7:0] DEF_ID_VALUE   = 8'hA5;

    // The error counter sits directly above the ID register.
    localparam logic [7:0] ERR_CNT_OFFSET = 8'h01;

    // Encoding of mem_wr_rd_s.
    localparam logic MEM_WRITE = 1'b1;
    localparam logic MEM_READ  = 1'b0;

    // True when addr selects one of the num_ports port-address registers.
    function automatic logic is_port_addr(input logic [7:0] addr, input int num_ports);
        return ({24'd0, addr} < 32'(num_ports));
    endfunction

endpackage

// File: rtl/switch_cfg_regs_if.sv
// switch_cfg_regs_if: memory configuration bus between the driver (master)
// and the switch-side register slave.
interface switch_cfg_regs_if;

    logic       mem_sel_en;
    logic [7:0] mem_addr;
    logic [7:0] mem_wr_data;
    logic       mem_wr_rd_s;
    logic [7:0] mem_rd_data;
    logic       mem_ack;

    modport master (
        output mem_sel_en,
        output mem_addr,
        output mem_wr_data,
        output mem_wr_rd_s,
        input  mem_rd_data,
        input  mem_ack
    );

    modport slave (
        input  mem_sel_en,
        input  mem_addr,
        input  mem_wr_data,
        input  mem_wr_rd_s,
        output mem_rd_data,
        output mem_ack
    );

endinterface

// File: rtl/switch_cfg_regfile.sv
// switch_cfg_regfile: per-port destination-address registers with their
// "configured" flags. One shared index serves the write port and the
// combinational read mux, since an access only ever touches one register.
module switch_cfg_regfile #(
    parameter int NUM_PORTS = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [7:0]             idx,
    input  logic [7:0]             wr_data,
    output logic [7:0]             rd_data,
    output logic [NUM_PORTS*8-1:0] port_addr,
    output logic [NUM_PORTS-1:0]   port_cfg_valid
);

    logic [NUM_PORTS-1:0][7:0] regs_q;
    logic [NUM_PORTS-1:0]      valid_q;

    assign port_addr      = regs_q;
    assign port_cfg_valid = valid_q;

    // Commit a write to the selected port register and mark it configured.
    // NOTE: this array is reset because the routing logic consumes it
    // directly; an unreset value would route traffic to random ports.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q  <= '0;
            valid_q <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (idx == 8'(i)) begin
                    // NOTE: non-blocking so every flop in this block samples
                    // pre-edge values regardless of statement order.
                    regs_q[i]  <= wr_data;
                    valid_q[i] <= 1'b1;
                end
            end
        end
    end

    // Select the addressed port register; out-of-range indices read zero.
    always_comb begin
        // NOTE: default first so no path leaves rd_data unassigned (no latch).
        rd_data = 8'h00;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (idx == 8'(i)) begin
                rd_data = regs_q[i];
            end
        end
    end

endmodule

// File: rtl/switch_cfg_regs.sv
// switch_cfg_regs: switch-side slave of the memory configuration bus.
// Holds NUM_PORTS destination-address registers plus a read-only ID
// register, acks every access with a one-cycle strobe, and accepts only
// one access per mem_sel_en assertion.
// Optional: define SWITCH_CFG_ERR_CNT_EN to add a saturating counter of
// accesses to unmapped addresses, readable (and cleared by a write) at
// ID_ADDR+1.
module switch_cfg_regs
    import switch_cfg_pkg::*;
#(
    parameter int         NUM_PORTS = 4,
    parameter logic [7:0] ID_ADDR   = DEF_ID_ADDR,
    parameter logic [7:0] ID_VALUE  = DEF_ID_VALUE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    switch_cfg_regs_if.slave       bus,
    output logic [NUM_PORTS*8-1:0] port_addr,
    output logic [NUM_PORTS-1:0]   port_cfg_valid
);

    localparam logic [1:0] S_IDLE     = IDLE;
    localparam logic [1:0] S_ACCESS   = ACCESS;
    localparam logic [1:0] S_ACK      = ACK;
    localparam logic [1:0] S_WAIT_REL = WAIT_REL;

    logic [1:0] state_q;
    logic [7:0] lat_addr_q;
    logic [7:0] lat_data_q;
    logic       lat_wr_q;
    logic       ack_q;
    logic [7:0] rd_data_q;

    logic       port_hit;
    logic       id_hit;
    logic       unmapped;
    logic       rf_wr_en;
    logic [7:0] rf_rd_data;
    logic [7:0] rd_next;

    assign port_hit = is_port_addr(lat_addr_q, NUM_PORTS);
    assign id_hit   = (lat_addr_q == ID_ADDR);

`ifdef SWITCH_CFG_ERR_CNT_EN
    localparam logic [7:0] ERR_CNT_ADDR = ID_ADDR + ERR_CNT_OFFSET;

    logic       err_hit;
    logic [7:0] err_cnt_q;

    assign err_hit  = (lat_addr_q == ERR_CNT_ADDR);
    assign unmapped = !port_hit && !id_hit && !err_hit;
`else
    assign unmapped = !port_hit && !id_hit;
`endif

    // Port registers change only in ACCESS, so a write is visible from the
    // edge that also raises mem_ack.
    assign rf_wr_en = (state_q == S_ACCESS) && (lat_wr_q == MEM_WRITE) && port_hit;

    switch_cfg_regfile #(
        .NUM_PORTS (NUM_PORTS)
    ) u_regfile (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr_en          (rf_wr_en),
        .idx            (lat_addr_q),
        .wr_data        (lat_data_q),
        .rd_data        (rf_rd_data),
        .port_addr      (port_addr),
        .port_cfg_valid (port_cfg_valid)
    );

    // Read data for the latched access; writes and unmapped reads return zero.
    always_comb begin
        rd_next = 8'h00;
        if (lat_wr_q == MEM_READ) begin
            if (port_hit) begin
                rd_next = rf_rd_data;
            end else if (id_hit) begin
                rd_next = ID_VALUE;
            end
`ifdef SWITCH_CFG_ERR_CNT_EN
            else if (err_hit) begin
                rd_next = err_cnt_q;
            end
`endif
        end
    end

    // Bus FSM: latch the request, complete it, ack once, then wait for release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            lat_addr_q <= 8'h00;
            lat_data_q <= 8'h00;
            lat_wr_q   <= MEM_READ;
            ack_q      <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.mem_sel_en) begin
                        lat_addr_q <= bus.mem_addr;
                        lat_data_q <= bus.mem_wr_data;
                        lat_wr_q   <= bus.mem_wr_rd_s;
                        state_q    <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // Committed once latched: sel_en is not looked at here.
                    ack_q     <= 1'b1;
                    rd_data_q <= rd_next;
                    state_q   <= S_ACK;
                end
                S_ACK: begin
                    ack_q     <= 1'b0;
                    rd_data_q <= 8'h00;
                    state_q   <= bus.mem_sel_en ? S_WAIT_REL : S_IDLE;
                end
                S_WAIT_REL: begin
                    if (!bus.mem_sel_en) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

`ifdef SWITCH_CFG_ERR_CNT_EN
    // Count committed accesses to unmapped addresses, saturating at 8'hFF;
    // any write to the counter's own address clears it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else if (state_q == S_ACCESS) begin
            if ((lat_wr_q == MEM_WRITE) && err_hit) begin
                err_cnt_q <= 8'h00;
            end else if (unmapped && (err_cnt_q != 8'hFF)) begin
                err_cnt_q <= err_cnt_q + 8'h01;
            end
        end
    end
`endif

    assign bus.mem_ack     = ack_q;
    assign bus.mem_rd_data = rd_data_q;

endmodule

// File: tb/tb_switch_cfg_regs.sv
// tb_switch_cfg_regs: directed self-checking bench for switch_cfg_regs.
// Covers the SWITCH_CFG_ERR_CNT_EN counter when the macro is defined and
// the plain unmapped behaviour of ID_ADDR+1 otherwise.
module tb_switch_cfg_regs;
    import switch_cfg_pkg::*;

    localparam int NUM_PORTS = 4;

    logic                   clk;
    logic                   rst_n;
    logic [NUM_PORTS*8-1:0] port_addr;
    logic [NUM_PORTS-1:0]   port_cfg_valid;

    int checks = 0;
    int errors = 0;

    switch_cfg_regs_if bus ();

    switch_cfg_regs #(
        .NUM_PORTS (NUM_PORTS)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .port_addr      (port_addr),
        .port_cfg_valid (port_cfg_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the stimulus ever stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One complete access: request at a negedge, release sel_en as soon as the
    // ack is seen, and watch 8 cycles to count ack pulses and their latency.
    task automatic access(input logic [7:0] a, input logic [7:0] d, input logic wr,
                          output logic [7:0] rd, output int acks, output int first_ack);
        @(negedge clk);
        bus.mem_addr    = a;
        bus.mem_wr_data = d;
        bus.mem_wr_rd_s = wr;
        bus.mem_sel_en  = 1'b1;
        acks      = 0;
        first_ack = -1;
        rd        = 8'h00;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.mem_ack === 1'b1) begin
                if (first_ack < 0) first_ack = i;
                acks++;
                rd = bus.mem_rd_data;
                bus.mem_sel_en = 1'b0;
            end
        end
        bus.mem_sel_en = 1'b0;
    endtask

    logic [7:0] rd;
    int         acks;
    int         lat;

    initial begin
        rst_n           = 1'b0;
        bus.mem_sel_en  = 1'b1;
        bus.mem_addr    = 8'h02;
        bus.mem_wr_data = 8'h5A;
        bus.mem_wr_rd_s = MEM_WRITE;

        // Reset held 3 cycles with a request pending: nothing may happen.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_ack", 32'(bus.mem_ack), 32'd0);
            check("rst_rd_data", 32'(bus.mem_rd_data), 32'h00);
        end
        check("rst_port_addr", port_addr, 32'h0000_0000);
        check("rst_cfg_valid", 32'(port_cfg_valid), 32'h0);
        check("rst_state", 32'(dut.state_q), 32'(IDLE));
        bus.mem_sel_en = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write 3C to port 2, then read it back.
        access(8'h02, 8'h3C, MEM_WRITE, rd, acks, lat);
        check("wr2_acks", 32'(acks), 32'd1);
        check("wr2_latency", 32'(lat), 32'd1);
        check("wr2_rd_data", 32'(rd), 32'h00);
        check("wr2_cfg_valid", 32'(port_cfg_valid), 32'b0100);
        check("wr2_port_byte", 32'(port_addr[23:16]), 32'h3C);
        check("wr2_port_addr", port_addr, 32'h003C_0000);

        access(8'h02, 8'h00, MEM_READ, rd, acks, lat);
        check("rd2_acks", 32'(acks), 32'd1);
        check("rd2_latency", 32'(lat), 32'd1);
        check("rd2_data", 32'(rd), 32'h3C);

        // Read-only ID register.
        access(8'h10, 8'h00, MEM_READ, rd, acks, lat);
        check("id_acks", 32'(acks), 32'd1);
        check("id_data", 32'(rd), 32'hA5);
        access(8'h10, 8'hFF, MEM_WRITE, rd, acks, lat);
        check("id_wr_acks", 32'(acks), 32'd1);
        check("id_wr_port_addr", port_addr, 32'h003C_0000);
        access(8'h10, 8'h00, MEM_READ, rd, acks, lat);
        check("id_reread", 32'(rd), 32'hA5);

        // Unmapped read returns zero but is still acked.
        access(8'h40, 8'h00, MEM_READ, rd, acks, lat);
        check("unmap_acks", 32'(acks), 32'd1);
        check("unmap_data", 32'(rd), 32'h00);

        // sel_en held for 6 cycles: one ack, park in WAIT_REL, no re-access
        // even though the bus contents change while held.
        @(negedge clk);
        bus.mem_addr    = 8'h01;
        bus.mem_wr_data = 8'h11;
        bus.mem_wr_rd_s = MEM_WRITE;
        bus.mem_sel_en  = 1'b1;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.mem_ack === 1'b1) acks++;
            if (i == 2) bus.mem_wr_data = 8'h22;
        end
        check("hold_acks", 32'(acks), 32'd1);
        check("hold_state", 32'(dut.state_q), 32'(WAIT_REL));
        check("hold_port1", 32'(port_addr[15:8]), 32'h11);
        bus.mem_sel_en = 1'b0;
        repeat (2) @(negedge clk);
        check("hold_release_state", 32'(dut.state_q), 32'(IDLE));
        check("hold_port1_after", 32'(port_addr[15:8]), 32'h11);
        check("hold_cfg_valid", 32'(port_cfg_valid), 32'b0110);

        // sel_en dropped right after the request is sampled: still committed.
        @(negedge clk);
        bus.mem_addr    = 8'h00;
        bus.mem_wr_data = 8'h77;
        bus.mem_wr_rd_s = MEM_WRITE;
        bus.mem_sel_en  = 1'b1;
        @(negedge clk);
        bus.mem_sel_en = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.mem_ack === 1'b1) acks++;
        end
        check("drop_acks", 32'(acks), 32'd1);
        check("drop_port0", 32'(port_addr[7:0]), 32'h77);
        check("drop_cfg_valid", 32'(port_cfg_valid), 32'b0111);

        // Reset while in ACCESS: no ack, no commit.
        @(negedge clk);
        bus.mem_addr    = 8'h03;
        bus.mem_wr_data = 8'h99;
        bus.mem_wr_rd_s = MEM_WRITE;
        bus.mem_sel_en  = 1'b1;
        @(negedge clk);
        check("abort_in_access", 32'(dut.state_q), 32'(ACCESS));
        rst_n          = 1'b0;
        bus.mem_sel_en = 1'b0;
        acks = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.mem_ack === 1'b1) acks++;
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_acks", 32'(acks), 32'd0);
        check("abort_port3", 32'(port_addr[31:24]), 32'h00);
        check("abort_cfg_valid", 32'(port_cfg_valid), 32'h0);

`ifdef SWITCH_CFG_ERR_CNT_EN
        // Error counter: counts unmapped accesses, clears on write, saturates.
        access(8'h40, 8'h00, MEM_READ, rd, acks, lat);
        access(8'h40, 8'h12, MEM_WRITE, rd, acks, lat);
        access(8'h40, 8'h00, MEM_READ, rd, acks, lat);
        access(8'h11, 8'h00, MEM_READ, rd, acks, lat);
        check("errcnt_three", 32'(rd), 32'h03);
        access(8'h10, 8'h00, MEM_READ, rd, acks, lat);
        access(8'h11, 8'h00, MEM_READ, rd, acks, lat);
        check("errcnt_id_not_counted", 32'(rd), 32'h03);
        access(8'h11, 8'h5A, MEM_WRITE, rd, acks, lat);
        check("errcnt_clr_acks", 32'(acks), 32'd1);
        access(8'h11, 8'h00, MEM_READ, rd, acks, lat);
        check("errcnt_cleared", 32'(rd), 32'h00);
        for (int i = 0; i < 300; i++) begin
            access(8'h40, 8'h00, (i % 2 == 0) ? MEM_READ : MEM_WRITE, rd, acks, lat);
        end
        access(8'h11, 8'h00, MEM_READ, rd, acks, lat);
        check("errcnt_saturated", 32'(rd), 32'hFF);
`else
        // Without the counter, ID_ADDR+1 is just another unmapped address.
        access(8'h40, 8'h00, MEM_READ, rd, acks, lat);
        access(8'h11, 8'h00, MEM_READ, rd, acks, lat);
        check("addr11_acks", 32'(acks), 32'd1);
        check("addr11_unmapped", 32'(rd), 32'h00);
        access(8'h11, 8'h33, MEM_WRITE, rd, acks, lat);
        access(8'h11, 8'h00, MEM_READ, rd, acks, lat);
        check("addr11_after_wr", 32'(rd), 32'h00);
        check("addr11_port_addr", port_addr, 32'h0000_0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_cfg_regs.md
Name: switch_cfg_regs

Overview:
- Switch-side slave of the memory configuration bus. It consumes mem_sel_en/mem_addr/mem_wr_data/mem_wr_rd_s driven by the testbench driver and produces mem_rd_data/mem_ack.
- Holds one 8-bit destination-address register per output port, plus a read-only ID register.
- Presents the configured addresses to the switch routing logic.
- Every access completes with a one-cycle ack; a master may not start another access until it has released sel_en.

Parameters:
- NUM_PORTS, 4, number of port-address registers, mapped at mem_addr 0..NUM_PORTS-1; legal range 1..16.
- ID_ADDR, 8'h10, address of the read-only ID register.
- ID_VALUE, 8'hA5, value returned when ID_ADDR is read.

Ports:
- clk  in  1  clock (from clk_rst_if).
- rst_n  in  1  reset, synchronous, active-low.
- mem_sel_en  in  1  access request; held high until mem_ack is seen.
- mem_addr  in  8  register address; stable while mem_sel_en is high.
- mem_wr_data  in  8  write data.
- mem_wr_rd_s  in  1  1 = write, 0 = read.
- mem_rd_data  out  8  read data; valid only while mem_ack is high.
- mem_ack  out  1  single-cycle completion strobe.
- port_addr  out  NUM_PORTS*8  flattened port-address registers; port i occupies bits [8i+7:8i].
- port_cfg_valid  out  NUM_PORTS  bit i set once port i has been written.

Behaviour:
- Reset: synchronous, active-low. When rst_n is sampled low at a clk edge:
  - state goes to IDLE;
  - mem_ack=0, mem_rd_data=8'h00;
  - all port_addr bytes = 8'h00, port_cfg_valid=0;
  - the error counter (if present) = 0.
- Reset mid-access aborts the access: no write is committed and no ack is issued.
- FSM states: IDLE, ACCESS, ACK, WAIT_REL.
  - IDLE: when mem_sel_en=1 at edge N, latch addr, data and wr_rd_s, then go to ACCESS.
  - ACCESS: at edge N+1, commit the write or register the read data, set mem_ack=1, go to ACK.
  - ACK: mem_ack is high for exactly the cycle between edges N+1 and N+2. At edge N+2, mem_ack=0 and mem_rd_data=0. Go to WAIT_REL if mem_sel_en=1, otherwise to IDLE.
  - WAIT_REL: stay until mem_sel_en=0, then go to IDLE. This guarantees one access per sel_en assertion.
- Latency: request sampled at edge N; ack visible at edge N+2 from the monitor's clocking-block point of view.
- Commit rule: once sampled in IDLE, an access is committed. Deasserting mem_sel_en during ACCESS or ACK does not cancel it.
- Writes:
  - addr < NUM_PORTS: port_addr[addr] = wr_data and port_cfg_valid[addr] is set; both visible from edge N+1.
  - Write to ID_ADDR or to an unmapped address: ignored, still acked.
- Reads:
  - addr < NUM_PORTS: returns that port's register.
  - ID_ADDR: returns ID_VALUE.
  - Unmapped address: returns 8'h00, still acked.
- mem_rd_data is 8'h00 outside ACK and during write acks.
- Simultaneous events: a write that lands in the same cycle the routing logic samples port_addr is seen with its new value from edge N+1 on. There are no other writers.

Optional Feature:
- Macro: SWITCH_CFG_ERR_CNT_EN.
- When defined:
  - an 8-bit saturating counter increments on every committed access to an unmapped address (read or write; ID_ADDR counts as mapped);
  - the counter saturates at 8'hFF;
  - it is readable at ID_ADDR+1 (8'h11);
  - a write to 8'h11 of any value clears it to 0.
- When not defined: 8'h11 is an ordinary unmapped address and no counter logic exists.

Decomposition:
- Package switch_cfg_pkg holds:
  - the FSM state enum typedef (IDLE, ACCESS, ACK, WAIT_REL);
  - the default ID_ADDR/ID_VALUE constants;
  - the ERR_CNT_ADDR offset;
  - the MEM_WRITE=1 / MEM_READ=0 constants.
- One natural sub-module, switch_cfg_regfile: the port-address array with write-enable/index inputs, a combinational read mux and the valid bits. The top level keeps the FSM and the ack/rd_data registers.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with sel_en=1 -> ack stays 0, rd_data=00, port_addr all 00, port_cfg_valid=0.
- Write 8'h3C to addr 2, then read addr 2 -> ack pulses exactly one cycle each; read returns 3C; port_cfg_valid=4'b0100; port_addr[23:16]=3C.
- Read ID_ADDR 8'h10 -> rd_data=A5 during ack. Write 8'hFF to 8'h10, then re-read -> still A5.
- Hold sel_en high for 6 cycles on a write to addr 1 with data 8'h11 -> exactly one ack; FSM parks in WAIT_REL; no second commit.
- Drop sel_en the cycle after the request on a write to addr 0 with data 8'h77 -> write still committed and acked. Separately, assert rst_n=0 in ACCESS -> no ack, register stays 00.
- With SWITCH_CFG_ERR_CNT_EN: 3 accesses to 8'h40 -> read of 8'h11 returns 03. Write to 8'h11 -> next read returns 00. 300 bad accesses -> read returns FF.
